jt12_slotreg: RTL
=================

# jt12_slotreg

Parametrised per-slot register file and slot sequencer for the FM core. It steps a time-multiplexed slot counter through every (operator, channel) pair and circulates one DW-bit register word per slot through a small RAM. It presents the current slot's word to the PG/EG/OP pipeline. Host writes are accepted through a request/busy handshake and merged bit-masked into the target slot when that slot next comes round; channel count, operator count and word width are all generic.

## Interface
- CH, 6, number of channels (1..8)
- OPS, 4, operators per channel (1..4)
- DW, 32, register word width per slot
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- clk_en  in  1  slot advance enable
- wr_req  in  1  write request
- wr_ch  in  3  target channel
- wr_op  in  2  target operator
- wr_mask  in  DW  bit mask, 1 = bit replaced
- wr_data  in  DW  write data
- busy  out  1  request cannot be accepted
- wr_done  out  1  one-clk pulse: a write was merged
- wr_err  out  1  one-clk pulse: out-of-range request rejected
- ready  out  1  post-reset clear pass finished
- cur_ch  out  3  channel of current slot
- cur_op  out  2  operator of current slot
- zero  out  1  current slot is slot 0
- slot_q  out  DW  stored word of current slot

## Operation
- N = CH*OPS slots. Slot index = cur_op*CH + cur_ch; channel is the inner counter. On each clk_en edge: cur_ch increments; at CH-1 it wraps to 0 and cur_op increments; at (OPS-1, CH-1) both wrap to 0.
- zero = 1 while (cur_op, cur_ch) = (0, 0).
- RAM: read address = next slot, write address = current slot, both acting on clk_en. slot_q is the registered read data, so it always belongs to cur.
- Writeback every clk_en: slot_q, or (slot_q & ~wr_mask_p) | (wr_data_p & wr_mask_p) when the pending write targets cur.
- Accept: on any clk edge with wr_req=1, busy=0, ready=1. An accepted request is loaded into the pending register.
- Reject: wr_ch ≥ CH or wr_op ≥ OPS. The request is not stored, wr_err pulses on the next clk and busy is unchanged.
- Apply: on the first clk_en edge strictly after acceptance where cur matches the target. wr_done pulses on the clk after the merge. The pending entry is then freed.
- slot_q still shows the old word during the merging cycle. The new value appears when the slot next recurs, N clk_en ticks later.
- Clear pass: after rst_n releases, ready=0 and every slot is written with 0 over N clk_en ticks, starting at slot 0. ready rises on the clk_en edge that writes slot N-1. Requests are not accepted while ready=0, and busy=1 during that time.

## Timing
- Reset values (rst_n=0 on a clk edge): cur_ch=0, cur_op=0, zero=1, slot_q=0, busy=1, ready=0, wr_done=0, wr_err=0, pending/queue empty.
- Reset mid-write discards the pending write; its wr_done never fires.
- Acceptance is sampled on every clk, independent of clk_en. Merging happens only on clk_en.
- Write latency is 1..N clk_en ticks after acceptance. If the target equals cur in the acceptance cycle, the write waits a full revolution (N ticks).
- busy rises on the clk after acceptance and falls on the clk after the merge. wr_done and the falling edge of busy occur in the same cycle.
- With clk_en held low, the slot counter, slot_q and the pending write all freeze. busy stays high.

## Configuration
- JT12_SLOTREG_QUEUE_EN undefined: a single pending entry.
  - busy=1 from acceptance until the merge.
  - wr_req while busy is ignored, with no error.
- JT12_SLOTREG_QUEUE_EN defined: a 4-entry FIFO of requests; only the head is compared against cur.
  - busy = FIFO full.
  - Accept and merge in the same clk: occupancy is unchanged.
  - Entries for the same slot merge in order on successive revolutions.

## Test plan
- Reset, CH=6 OPS=4 DW=32: rst_n low 2 clk, clk_en=1 -> ready rises after exactly 24 clk_en edges; zero=1 every 24th tick; all slot_q=0 for one revolution.
- Write ch=2 op=1 mask=0x0000FFFF data=0x1234ABCD over stored 0x55550000 -> slot index 8 reads 0x5555ABCD next revolution; wr_done pulses once; other slots are unchanged.
- Request whose target equals cur in the acceptance cycle -> merged 24 clk_en ticks later, not 0.
- wr_ch=6 -> wr_err pulses 1 clk; busy stays 0; no slot changes.
- clk_en=0 for 10 clk during a pending write -> cur, slot_q and busy are frozen; the write completes after resumption with the correct latency.
- Queue build: 5 back-to-back requests -> busy=1 after the 4th and the 5th is ignored. Without the macro: busy after the 1st, and the 2nd–5th are ignored.

Source files
------------

// File: rtl/jt12_slotreg.sv
`default_nettype none
// ============================================================================
// Module   : jt12_slotreg
// Purpose  : Per-slot register file and (operator, channel) slot sequencer
//            with bit-masked host writes merged when the target slot recurs.
// Option   : JT12_SLOTREG_QUEUE_EN enables a 4-entry pending-write FIFO.
// Revision : 1.0
// ============================================================================
module jt12_slotreg #(
   parameter int CH  = 6,
   parameter int OPS = 4,
   parameter int DW  = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clk_en,
   input  logic          wr_req,
   input  logic [2:0]    wr_ch,
   input  logic [1:0]    wr_op,
   input  logic [DW-1:0] wr_mask,
   input  logic [DW-1:0] wr_data,
   output logic          busy,
   output logic          wr_done,
   output logic          wr_err,
   output logic          ready,
   output logic [2:0]    cur_ch,
   output logic [1:0]    cur_op,
   output logic          zero,
   output logic [DW-1:0] slot_q
);
   localparam int N  = CH * OPS;
   localparam int SW = (N > 1) ? $clog2(N) : 1;
`ifdef JT12_SLOTREG_QUEUE_EN
   localparam int QDEPTH = 4;
`else
   localparam int QDEPTH = 1;
`endif
   localparam logic [2:0]    CH_LAST   = 3'(CH - 1);
   localparam logic [1:0]    OP_LAST   = 2'(OPS - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(N - 1);
   localparam logic [2:0]    Q_FULL    = 3'(QDEPTH);

   logic [DW-1:0] mem [0:N-1];

   logic [2:0]    ch_q, ch_d, nxt_ch;
   logic [1:0]    op_q, op_d, nxt_op;
   logic          ready_q, ready_d;
   logic [DW-1:0] slot_d, wb;
   logic          wr_done_q, wr_done_d, wr_err_q, wr_err_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [2:0]    f_ch_q   [0:3];
   logic [2:0]    f_ch_d   [0:3];
   logic [1:0]    f_op_q   [0:3];
   logic [1:0]    f_op_d   [0:3];
   logic [DW-1:0] f_mask_q [0:3];
   logic [DW-1:0] f_mask_d [0:3];
   logic [DW-1:0] f_data_q [0:3];
   logic [DW-1:0] f_data_d [0:3];
   logic [SW-1:0] cur_idx, nxt_idx;
   logic          head_hit, merge, full, in_range, take, accept, reject;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      nxt_ch = ch_q + 3'd1;
      nxt_op = op_q;
      if (ch_q == CH_LAST) begin
         nxt_ch = 3'd0;
         nxt_op = (op_q == OP_LAST) ? 2'd0 : op_q + 2'd1;
      end
      cur_idx = SW'(int'(op_q) * CH + int'(ch_q));
      nxt_idx = SW'(int'(nxt_op) * CH + int'(nxt_ch));
   end

   // Only the oldest pending request is ever compared against the current slot.
   always_comb begin
      head_hit = (cnt_q != 3'd0) && (f_ch_q[rd_ptr_q] == ch_q) && (f_op_q[rd_ptr_q] == op_q);
      merge    = clk_en && ready_q && head_hit;
      full     = (cnt_q == Q_FULL);
      busy     = !ready_q || full;
      in_range = (int'(wr_ch) < CH) && (int'(wr_op) < OPS);
      take     = wr_req && !busy;
      accept   = take && in_range;
      reject   = take && !in_range;
      wb       = '0;
      if (ready_q) begin
         wb = merge ? ((slot_q & ~f_mask_q[rd_ptr_q]) | (f_data_q[rd_ptr_q] & f_mask_q[rd_ptr_q]))
                    : slot_q;
      end
   end

   always_comb begin
      ch_d      = ch_q;
      op_d      = op_q;
      ready_d   = ready_q;
      slot_d    = slot_q;
      wr_done_d = merge;
      wr_err_d  = reject;
      cnt_d     = cnt_q + {2'b00, accept} - {2'b00, merge};
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      f_ch_d    = f_ch_q;
      f_op_d    = f_op_q;
      f_mask_d  = f_mask_q;
      f_data_d  = f_data_q;
      if (clk_en) begin
         ch_d = nxt_ch;
         op_d = nxt_op;
         // While clearing, the RAM may still hold stale data: present zeros.
         if (nxt_idx == cur_idx) begin
            slot_d = wb;
         end else begin
            slot_d = ready_q ? mem[nxt_idx] : '0;
         end
         if (!ready_q && (cur_idx == SLOT_LAST)) begin
            ready_d = 1'b1;
         end
      end
      if (accept) begin
         f_ch_d[wr_ptr_q]   = wr_ch;
         f_op_d[wr_ptr_q]   = wr_op;
         f_mask_d[wr_ptr_q] = wr_mask;
         f_data_d[wr_ptr_q] = wr_data;
         wr_ptr_d           = ptr_inc(wr_ptr_q);
      end
      if (merge) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch_q      <= 3'd0;
         op_q      <= 2'd0;
         ready_q   <= 1'b0;
         slot_q    <= '0;
         wr_done_q <= 1'b0;
         wr_err_q  <= 1'b0;
         cnt_q     <= 3'd0;
         rd_ptr_q  <= 2'd0;
         wr_ptr_q  <= 2'd0;
      end else begin
         ch_q      <= ch_d;
         op_q      <= op_d;
         ready_q   <= ready_d;
         slot_q    <= slot_d;
         wr_done_q <= wr_done_d;
         wr_err_q  <= wr_err_d;
         cnt_q     <= cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      f_ch_q   <= f_ch_d;
      f_op_q   <= f_op_d;
      f_mask_q <= f_mask_d;
      f_data_q <= f_data_d;
   end

   always_ff @(posedge clk) begin
      if (rst_n && clk_en) begin
         mem[cur_idx] <= wb;
      end
   end

   assign wr_done = wr_done_q;
   assign wr_err  = wr_err_q;
   assign ready   = ready_q;
   assign cur_ch  = ch_q;
   assign cur_op  = op_q;
   assign zero    = (ch_q == 3'd0) && (op_q == 2'd0);
endmodule
`default_nettype wire
